// File: rtl/intra4x4_mode_sched_if.sv
// intra4x4_mode_sched_if: control, predictor/SAD and result handshake bundle of the intra 4x4 mode scheduler
interface intra4x4_mode_sched_if #(
  parameter int NUM_MODES = 8,
  parameter int SAD_W     = 8
);
  logic                 start;
  logic [NUM_MODES-1:0] avail_mask;
  logic                 pred_req;
  logic                 pred_ack;
  logic                 sad_en;
  logic [SAD_W-1:0]     sads [NUM_MODES];
  logic [3:0]           blk_idx;
  logic                 out_valid;
  logic                 out_ready;
  logic [2:0]           best_mode;
  logic [SAD_W-1:0]     best_sad;
  logic                 no_mode;
  logic [SAD_W+3:0]     mb_cost;
  logic                 busy;
  logic                 done;
  modport master (
    output start, avail_mask, pred_ack, sads, out_ready,
    input  pred_req, sad_en, blk_idx, out_valid, best_mode, best_sad, no_mode, mb_cost, busy, done
  );
  modport slave (
    input  start, avail_mask, pred_ack, sads, out_ready,
    output pred_req, sad_en, blk_idx, out_valid, best_mode, best_sad, no_mode, mb_cost, busy, done
  );
endinterface

// File: rtl/intra4x4_mode_sched.sv
// intra4x4_mode_sched: per-4x4-block predictor/SAD sequencing and serial min-SAD mode pick across one macroblock
module intra4x4_mode_sched #(
  parameter int NUM_BLK   = 16,
  parameter int NUM_MODES = 8,
  parameter int SAD_W     = 8,
  parameter int SAD_LAT   = 1
) (
  input logic                  clk,
  input logic                  reset,
  intra4x4_mode_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PRED, SAD, WAIT, CMP, OUT, FIN} state_t;
  localparam int LW = SAD_LAT > 1 ? $clog2(SAD_LAT) : 1;
  state_t               state, nxt;
  logic [NUM_MODES-1:0] mask;
  logic [3:0]           blk;
  logic [2:0]           m, idx;
  logic [LW-1:0]        wcnt;
  logic [SAD_W-1:0]     min_v;
  logic                 found;
  logic [SAD_W+3:0]     cost;
  logic                 hs, last_m, last_blk, take;
  assign hs       = state == OUT && bus.out_ready;
  assign last_m   = m == 3'(NUM_MODES - 1);
  assign last_blk = blk == 4'(NUM_BLK - 1);
  // strict less-than keeps the lowest mode index on ties
  assign take     = mask[m] && (!found || bus.sads[m] < min_v);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start ? PRED : IDLE;
      PRED:    nxt = bus.pred_ack ? SAD : PRED;
      SAD:     nxt = WAIT;
      WAIT:    nxt = wcnt == LW'(SAD_LAT - 1) ? CMP : WAIT;
      CMP:     nxt = last_m ? OUT : CMP;
      OUT:     nxt = !bus.out_ready ? OUT : last_blk ? FIN : PRED;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mask  <= '0;
      blk   <= '0;
      m     <= '0;
      idx   <= '0;
      wcnt  <= '0;
      min_v <= '1;
      found <= 1'b0;
      cost  <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        mask <= bus.avail_mask;
        blk  <= '0;
        cost <= '0;
      end
      if (state == SAD) begin
        m     <= '0;
        idx   <= '0;
        min_v <= '1;
        found <= 1'b0;
        wcnt  <= '0;
      end
      if (state == WAIT) wcnt <= wcnt + LW'(1);
      if (state == CMP) begin
        m <= m + 3'd1;
        if (take) begin
          min_v <= bus.sads[m];
          idx   <= m;
          found <= 1'b1;
        end
      end
      if (hs) begin
        cost <= cost + (found ? (SAD_W+4)'(min_v) : '0);
        if (!last_blk) blk <= blk + 4'd1;
      end
    end
  assign bus.pred_req  = state == PRED;
  assign bus.sad_en    = state == SAD;
  assign bus.out_valid = state == OUT;
  assign bus.busy      = state != IDLE;
  assign bus.done      = state == FIN;
  assign bus.blk_idx   = blk;
  assign bus.best_mode = idx;
  assign bus.best_sad  = min_v;
  assign bus.no_mode   = state == OUT && !found;
  assign bus.mb_cost   = cost;
endmodule

// File: tb/tb_intra4x4_mode_sched.sv
// tb_intra4x4_mode_sched: scoreboard bench with a min-over-enabled-modes reference model
module tb_intra4x4_mode_sched;
  localparam logic [63:0] FIXED = 64'h0D4D21C80C5A0C28;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  intra4x4_mode_sched_if #(.NUM_MODES(8), .SAD_W(8)) bus ();
  intra4x4_mode_sched #(.NUM_BLK(16), .NUM_MODES(8), .SAD_W(8), .SAD_LAT(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  int cmp_n = 0, err_n = 0, done_n = 0, exp_done = 0;
  int rdy_mode = 0, ack_delay = 0, bp_cnt = 0, ack_cnt = 0, exp_blk = 0, sad_en_cnt = 0;
  bit stray = 1'b0, load = 1'b0, have_snap = 1'b0;
  logic [11:0] eq [$];
  logic [11:0] cq [$];
  logic [63:0] sq [$];
  logic [11:0] run_sum = '0, e;
  logic [15:0] snap;
  logic [63:0] rs;

  task automatic chk(input string name, input int act, input int exp);
    cmp_n++;
    if (act != exp) begin
      err_n++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // best = smallest SAD among enabled modes, lowest index among equals; packed {no_mode, mode, sad}
  function automatic logic [11:0] ref_blk(input logic [7:0] mask, input logic [63:0] s);
    int mn = 256;
    for (int i = 0; i < 8; i++) if (mask[i] && int'(s[i*8 +: 8]) < mn) mn = int'(s[i*8 +: 8]);
    if (mn == 256) return {1'b1, 3'd0, 8'hFF};
    for (int i = 0; i < 8; i++) if (mask[i] && int'(s[i*8 +: 8]) == mn) return {1'b0, 3'(i), 8'(mn)};
    return '0;
  endfunction

  // predictor / SAD unit / downstream responder
  initial begin
    bus.pred_ack  = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus.sads[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        bus.pred_ack = 1'b0;
        ack_cnt = 0;
        load = 1'b0;
      end else begin
        if (load && sq.size() > 0) begin
          rs = sq.pop_front();
          for (int i = 0; i < 8; i++) bus.sads[i] = rs[i*8 +: 8];
        end
        load = bus.sad_en;
        if (bus.pred_req) begin
          bus.pred_ack = ack_cnt >= ack_delay;
          ack_cnt = bus.pred_ack ? 0 : ack_cnt + 1;
        end else begin
          ack_cnt = 0;
          bus.pred_ack = stray && $urandom_range(0, 3) == 0;
        end
        if (rdy_mode == 0) bus.out_ready = 1'b1;
        else if (rdy_mode == 1) bus.out_ready = $urandom_range(0, 2) != 0;
        else if (bus.out_valid && bus.blk_idx == 4'd3 && bp_cnt < 5) begin
          bus.out_ready = 1'b0;
          bp_cnt++;
        end else bus.out_ready = 1'b1;
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    if (reset) begin
      run_sum = '0;
      have_snap = 1'b0;
      exp_blk = 0;
      sad_en_cnt = 0;
      eq.delete();
      cq.delete();
      sq.delete();
    end else begin
      if (bus.out_valid) begin
        chk("cost_hold", int'(bus.mb_cost), int'(run_sum));
        chk("req_low_in_out", int'(bus.pred_req), 0);
        if (have_snap)
          chk("out_stable", int'({bus.blk_idx, bus.no_mode, bus.best_mode, bus.best_sad}), int'(snap));
        if (bus.out_ready) begin
          if (eq.size() == 0) chk("unexpected_out", 1, 0);
          else begin
            e = eq.pop_front();
            chk("best_mode", int'(bus.best_mode), int'(e[10:8]));
            chk("best_sad", int'(bus.best_sad), int'(e[7:0]));
            chk("no_mode", int'(bus.no_mode), int'(e[11]));
            run_sum += e[11] ? 12'd0 : {4'd0, e[7:0]};
          end
          chk("blk_idx", int'(bus.blk_idx), exp_blk);
          chk("sad_en_pulses", sad_en_cnt, 1);
          exp_blk++;
          sad_en_cnt = 0;
          have_snap = 1'b0;
        end else begin
          snap = {bus.blk_idx, bus.no_mode, bus.best_mode, bus.best_sad};
          have_snap = 1'b1;
        end
      end
      if (bus.sad_en) sad_en_cnt++;
      if (bus.done) begin
        done_n++;
        if (cq.size() == 0) chk("unexpected_done", 1, 0);
        else chk("mb_cost", int'(bus.mb_cost), int'(cq.pop_front()));
        run_sum = '0;
        exp_blk = 0;
      end
    end
  end

  // kind: 0 fixed table, 1 all 255, 2 random, 3 random narrow range (many ties)
  task automatic run_mb(input logic [7:0] mask, input int kind, input int rm, input int ad,
                        input bit strays, input int abort_blk);
    logic [63:0] s, f;
    logic [11:0] r;
    logic [11:0] cost = '0;
    int first_ov = -1;
    bit fin = 1'b0;
    f = FIXED;
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 8; i++)
        s[i*8 +: 8] = kind == 0 ? f[i*8 +: 8] : kind == 1 ? 8'hFF :
                      kind == 2 ? 8'($urandom) : 8'($urandom_range(10, 13));
      r = ref_blk(mask, s);
      sq.push_back(s);
      eq.push_back(r);
      cost += r[11] ? 12'd0 : {4'd0, r[7:0]};
    end
    cq.push_back(cost);
    rdy_mode = rm;
    ack_delay = ad;
    stray = strays;
    bp_cnt = 0;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.avail_mask = mask;
    for (int n = 1; n < 3000 && !fin; n++) begin
      @(posedge clk);
      #1;
      bus.avail_mask = 8'($urandom);
      bus.start = strays && bus.busy && !bus.done && $urandom_range(0, 7) == 0;
      if (bus.out_valid && first_ov < 0) first_ov = n;
      if (abort_blk >= 0 && bus.sad_en && bus.blk_idx == 4'(abort_blk)) begin
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_valid", int'(bus.out_valid), 0);
        chk("abort_blk_idx", int'(bus.blk_idx), 0);
        chk("abort_done", int'(bus.done), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        return;
      end
      if (bus.done) fin = 1'b1;
    end
    if (!fin) begin
      chk("done_timeout", 0, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $fatal(1, "macroblock did not complete");
    end
    exp_done++;
    if (ad == 0) chk("first_out_latency", first_ov, 12);
    bus.start = strays;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("fin_start_ignored", int'(bus.busy), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.avail_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pred_req", int'(bus.pred_req), 0);
    chk("rst_sad_en", int'(bus.sad_en), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_blk_idx", int'(bus.blk_idx), 0);
    chk("rst_best_mode", int'(bus.best_mode), 0);
    chk("rst_best_sad", int'(bus.best_sad), 255);
    chk("rst_no_mode", int'(bus.no_mode), 0);
    chk("rst_mb_cost", int'(bus.mb_cost), 0);
    reset = 1'b0;
    run_mb(8'hFF, 0, 0, 0, 1'b0, -1);
    run_mb(8'hFD, 0, 0, 0, 1'b0, -1);
    run_mb(8'h00, 0, 1, 0, 1'b0, -1);
    run_mb(8'hFF, 1, 0, 0, 1'b0, -1);
    run_mb(8'hFF, 0, 2, 1, 1'b0, -1);
    run_mb(8'($urandom), 2, 1, 7, 1'b1, -1);
    run_mb(8'hFF, 2, 1, 2, 1'b0, 5);
    run_mb(8'hFF, 0, 0, 0, 1'b0, -1);
    for (int k = 0; k < 6; k++)
      run_mb(8'($urandom), k % 2 == 0 ? 2 : 3, 1, $urandom_range(0, 3), 1'b1, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", done_n, exp_done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule

// File: doc/intra4x4_mode_sched.md
Name: intra4x4_mode_sched

Overview:
- Sequences luma 4x4 intra mode decision across one macroblock.
- Per 4x4 block: requests residuals from the predictor, pulses the 8-mode SAD unit, then serially scans the 8 returned SADs for the minimum.
- Emits a best mode and SAD per block over a valid/ready handshake, then a macroblock cost and done pulse.
- Sits between the MB-level intra controller and the predictor/SAD datapath.

Parameters:
NUM_BLK, 16, 4x4 blocks per macroblock (power of 2, at most 16)
NUM_MODES, 8, SAD lanes scanned (index 0=V,1=H,2=VL,3=VR,4=HU,5=HD,6=DDL,7=DDR)
SAD_W, 8, width of each SAD lane, unsigned
SAD_LAT, 1, cycles from sad_en high to sads valid (at least 1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a macroblock; sampled only in IDLE
avail_mask  in  NUM_MODES  per-mode enable, 1=candidate; captured at start
pred_req  out  1  request residuals for block blk_idx
pred_ack  in  1  predictor residuals valid (1-cycle pulse)
sad_en  out  1  enable to SAD unit, 1-cycle pulse
sads  in  SAD_W x NUM_MODES  unpacked array of per-mode SADs
blk_idx  out  4  current block index
out_valid  out  1  best_mode/best_sad valid
out_ready  in  1  downstream accepts
best_mode  out  3  index of minimum SAD
best_sad  out  SAD_W  minimum SAD value
no_mode  out  1  avail_mask was all zero
mb_cost  out  SAD_W+4  sum of best_sad over the macroblock
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse after the last block is accepted

Behaviour:
- Reset values: state=IDLE; all outputs 0 except best_sad=all-ones. Reset mid-operation aborts immediately and emits no done. The SAD unit needs no flush.
- States: IDLE, PRED, SAD, WAIT, CMP, OUT, FIN.
- IDLE:
  - start=1 -> PRED next cycle.
  - On the same edge: capture avail_mask; clear blk_idx and mb_cost.
- PRED:
  - pred_req held high.
  - A cycle with pred_ack=1 -> SAD; pred_req drops on that edge.
  - pred_ack outside PRED is ignored.
- SAD:
  - sad_en=1 for exactly one cycle -> WAIT.
  - WAIT lasts SAD_LAT cycles, then CMP.
- CMP:
  - 3-bit mode counter m runs 0..NUM_MODES-1, one mode per cycle (8 cycles).
  - On entry: running min = all-ones, idx=0, found=0.
  - A mode updates the min when its mask bit is 1 AND (found=0 OR sads[m] < min). Set found=1 on update.
  - Strict less-than: ties keep the lower mode index.
  - After m=NUM_MODES-1 -> OUT.
  - sads must stay stable through CMP; the SAD unit holds its outputs while sad_en is low.
- OUT:
  - out_valid=1. best_mode, best_sad and no_mode (=~found) stay stable until the handshake.
  - Handshake cycle (out_valid & out_ready): mb_cost += best_sad (no_mode blocks add 0).
  - Same handshake: if blk_idx=NUM_BLK-1 -> FIN; else blk_idx+1 and -> PRED.
  - out_valid deasserts on the handshake edge.
- no_mode case: best_mode=0, best_sad=all-ones.
- FIN: done=1 for one cycle -> IDLE. mb_cost holds until the next start.
- start while busy is ignored. start in the FIN cycle is ignored; it is accepted one cycle later in IDLE.
- Arithmetic:
  - SADs are unsigned. No saturation of inputs (SAD lanes may already have wrapped).
  - mb_cost cannot overflow: 16*255=4080 < 4096.
- Minimum per-block latency, start/handshake to next out_valid: 1 PRED + 1 SAD + SAD_LAT + 8 CMP cycles, with pred_ack in the first PRED cycle.

Test Plan:
- Reset during CMP of block 5 -> next cycle busy=0, out_valid=0, blk_idx=0, no done. Fresh start then runs 16 blocks normally.
- Single MB, mask=8'hFF, sads={V=40,H=12,VL=90,VR=12,HU=200,HD=33,DDL=77,DDR=13} every block, out_ready tied 1:
  - each block -> best_mode=1, best_sad=12 (tie with VR resolved to H).
  - mb_cost=192; done pulses once.
  - out_valid first rises 12 cycles after start with pred_ack immediate.
- mask=8'b1111_1101, same sads -> best_mode=3, best_sad=12. mask=8'h00 -> no_mode=1, best_mode=0, best_sad=255, mb_cost=0.
- All SADs 255, mask=8'hFF -> best_mode=0, best_sad=255 per block; mb_cost=4080 (no wrap).
- Backpressure: out_ready low for 5 cycles at block 3 -> outputs stable and blk_idx=3 throughout; pred_req stays low; mb_cost updates only on the handshake edge.
- pred_ack delayed 7 cycles; start pulsed mid-run; stray pred_ack in CMP:
  - pred_req held; sad_en is a single pulse.
  - mid-run start and stray pred_ack have no effect.
